// File: rtl/frame_buffer_host.sv
// frame_buffer_host: host load/unload frame buffer with a controller RAM window.
// Define FB_BOUNDS_CHECK_EN to suppress out-of-frame controller writes and flag them on err_o.
module frame_buffer_host (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  dim_i,
  input  logic        in_valid_i,
  input  logic [7:0]  in_data_i,
  output logic        in_ready_o,
  output logic        out_valid_o,
  output logic [7:0]  out_data_o,
  input  logic        out_ready_i,
  output logic        ready_o,
  input  logic        start_i,
  input  logic [15:0] address_i,
  input  logic        write_enable_i,
  input  logic [7:0]  data_to_write_i,
  output logic [7:0]  pixel_data_o,
  output logic        err_o
);
  typedef enum logic [2:0] {IDLE, LOAD, HANDOFF, WAIT_DONE, UNLOAD} state_t;
  state_t state_q, state_d;
  logic [7:0] mem [65536];
  logic [16:0] cnt_q, cnt_d, n;
  logic [8:0] dim_q, dim_d;
  logic [7:0] pix_q, od_q, mem_wdata;
  logic [15:0] mem_addr;
  logic ov_q, ov_d, err_q, err_d, oob, mem_we, pix_en, od_ld;

  assign n = {8'd0, dim_q} * {8'd0, dim_q};
`ifdef FB_BOUNDS_CHECK_EN
  assign oob = {1'b0, address_i} >= n;
`else
  assign oob = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    dim_d = dim_q;
    ov_d = ov_q;
    err_d = err_q;
    mem_we = 1'b0;
    mem_addr = cnt_q[15:0];
    mem_wdata = in_data_i;
    pix_en = 1'b0;
    od_ld = 1'b0;
    case (state_q)
      IDLE: begin
        dim_d = (dim_i == 9'd0 || dim_i > 9'd256) ? 9'd256 : dim_i;
        cnt_d = '0;
        state_d = LOAD;
      end
      LOAD: if (in_valid_i) begin
        mem_we = 1'b1;
        cnt_d = cnt_q + 17'd1;
        state_d = (cnt_d == n) ? HANDOFF : LOAD;
      end
      HANDOFF: begin
        cnt_d = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        mem_addr = address_i;
        mem_wdata = data_to_write_i;
        mem_we = write_enable_i & ~oob;
        pix_en = ~oob;
        err_d = err_q | (write_enable_i & oob);
        state_d = start_i ? UNLOAD : WAIT_DONE;
      end
      UNLOAD: begin
        // refill the output register whenever it is empty or being drained this cycle
        od_ld = (~ov_q | out_ready_i) & (cnt_q != n);
        ov_d = od_ld | (ov_q & ~out_ready_i);
        cnt_d = od_ld ? cnt_q + 17'd1 : cnt_q;
        state_d = (ov_q & out_ready_i & cnt_q == n) ? IDLE : UNLOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      dim_q <= 9'd256;
      ov_q <= 1'b0;
      od_q <= '0;
      pix_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dim_q <= dim_d;
      ov_q <= ov_d;
      err_q <= err_d;
      pix_q <= pix_en ? mem[mem_addr] : 8'd0;
      if (od_ld) od_q <= mem[mem_addr];
    end

  assign in_ready_o = state_q == LOAD;
  assign ready_o = state_q == HANDOFF;
  assign out_valid_o = ov_q;
  assign out_data_o = od_q;
  assign pixel_data_o = pix_q;
  assign err_o = err_q;
endmodule

// File: tb/tb_frame_buffer_host.sv
// tb_frame_buffer_host: directed frame load / controller access / unload sequence with a scoreboard queue.
module tb_frame_buffer_host;
  logic clk = 1'b0, rst = 1'b1;
  logic [8:0] dim = 9'd4;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, ready, start = 1'b0, write_enable = 1'b0, err;
  logic [7:0] in_data = '0, out_data, data_to_write = '0, pixel_data;
  logic [15:0] address = '0;
  logic [7:0] model [65536];
  logic [7:0] sb [$];
  int passed = 0, total = 0, cur_n = 16;
  logic err_exp = 1'b0;

  always #5 clk = ~clk;

  frame_buffer_host dut (
    .clk(clk), .rst(rst), .dim_i(dim),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready),
    .ready_o(ready), .start_i(start), .address_i(address),
    .write_enable_i(write_enable), .data_to_write_i(data_to_write),
    .pixel_data_o(pixel_data), .err_o(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_reset();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ready", ready, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_pixel_data", pixel_data, 0);
    chk("rst_err", err, 0);
  endtask

  task automatic load(logic [8:0] d, int base, int beats);
    int i = 0, guard = 0, early = 0;
    dim = d;
    cur_n = (d == 0 || d > 256) ? 65536 : d * d;
    in_valid = 1'b1;
    while (i < beats && guard < beats + 10) begin
      in_data = 8'(base + i + (i >> 8));
      if (ready) early++;
      if (in_ready) begin
        model[i] = in_data;
        i++;
      end
      tick();
      guard++;
    end
    in_valid = 1'b0;
    chk("load_beats", i, beats);
    chk("ready_early", early, 0);
    if (beats == cur_n) begin
      chk("ready_pulse", ready, 1);
      tick();
      chk("ready_once", ready, 0);
      chk("in_ready_off", in_ready, 0);
    end
  endtask

  task automatic access(int a, logic we, logic [7:0] wd, logic chk_rd, string tag);
`ifdef FB_BOUNDS_CHECK_EN
    logic ok = a < cur_n;
`else
    logic ok = 1'b1;
`endif
    logic [7:0] e;
    address = 16'(a);
    write_enable = we;
    data_to_write = wd;
    sb.push_back(ok ? model[a] : 8'd0);
    if (we && ok) model[a] = wd;
    if (we && !ok) err_exp = 1'b1;
    tick();
    write_enable = 1'b0;
    e = sb.pop_front();
    if (chk_rd) chk(tag, pixel_data, e);
    chk({tag, "_err"}, err, err_exp);
  endtask

  task automatic go();
    address = 16'd3;
    write_enable = 1'b1;
    data_to_write = 8'h77;
    start = 1'b1;
    model[3] = 8'h77;
    tick();
    start = 1'b0;
    write_enable = 1'b0;
    for (int k = 0; k < cur_n; k++) sb.push_back(model[k]);
  endtask

  task automatic unload(int n, logic toggle);
    int got = 0, guard = 0, first = -1, last = 0;
    logic stalled = 1'b0;
    logic [7:0] hold = '0;
    while (got < n && guard < 4 * n + 20) begin
      out_ready = toggle ? (guard % 2 == 0) : 1'b1;
      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, hold);
      end
      stalled = 1'b0;
      if (out_valid && out_ready) begin
        chk("beat_data", out_data, sb.pop_front());
        got++;
        if (first < 0) first = guard;
        last = guard;
      end else if (out_valid) begin
        stalled = 1'b1;
        hold = out_data;
      end
      tick();
      guard++;
    end
    out_ready = 1'b0;
    chk("unload_beats", got, n);
    if (!toggle) chk("unload_back_to_back", last - first, n - 1);
    chk("unload_valid_off", out_valid, 0);
    chk("unload_sb_empty", sb.size(), 0);
  endtask

  initial begin
    #2;
    chk_reset();
    tick();
    rst = 1'b0;
    chk("idle_in_ready", in_ready, 0);
    load(9'd4, 0, 16);
    access(5, 1'b0, 8'h00, 1'b1, "rd5");
    access(5, 1'b1, 8'hAA, 1'b1, "wr5_old");
    access(5, 1'b0, 8'h00, 1'b1, "rd5_new");
    access(20, 1'b1, 8'h5C, 1'b0, "wr20");
    access(20, 1'b0, 8'h00, 1'b1, "rd20");
    go();
    unload(16, 1'b0);
    load(9'd3, 100, 9);
    access(8, 1'b0, 8'h00, 1'b1, "rd8");
    go();
    unload(9, 1'b1);
    load(9'd0, 0, 65536);
    access(0, 1'b0, 8'h00, 1'b1, "rd_first");
    access(65535, 1'b0, 8'h00, 1'b1, "rd_last");
    rst = 1'b1;
    #1;
    chk_reset();
    err_exp = 1'b0;
    sb.delete();
    tick();
    rst = 1'b0;
    load(9'd4, 200, 7);
    rst = 1'b1;
    #1;
    chk_reset();
    tick();
    rst = 1'b0;
    load(9'd4, 200, 16);
    access(0, 1'b0, 8'h00, 1'b1, "rd0_reload");
    go();
    unload(16, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
